// File: rtl/gty_dbg_pkg.sv
// Shared constants for the GTY TX debug pattern sequencer: address offsets,
// CTRL bit positions, sequencer state encoding and PRBS31 feedback taps.
package gty_dbg_pkg;

    localparam logic [11:0] OFF_CTRL = 12'h000;
    localparam logic [11:0] OFF_LAST = 12'h001;
    localparam logic [11:0] OFF_FLAG = 12'h010;
    localparam logic [11:0] OFF_PAT  = 12'h100;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_STOP  = 1;
    localparam int unsigned CTRL_LOOP  = 2;
    localparam int unsigned CTRL_PRBS  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    // x^31 + x^28 + 1 expressed as zero-based positions in a 31-bit shift register
    localparam int unsigned PRBS_TAP_A = 30;
    localparam int unsigned PRBS_TAP_B = 27;

endpackage

// File: rtl/gpio_byte_wr_decoder.sv
// Byte-wide GPIO write decoder: detects the w_clk rising edge, checks the 4 KiB
// address window and emits a one-cycle write pulse with word/byte-lane fields.
module gpio_byte_wr_decoder
    import gty_dbg_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    input  logic        w_clk,
    output logic        wr,
    output logic [7:0]  wr_word,
    output logic [3:0]  wr_lane,
    output logic [7:0]  wr_data
);

    logic        w_clk_q;
    logic        w_rise;
    logic [15:0] offset;
    logic        in_window;

    assign w_rise    = w_clk && !w_clk_q;
    assign offset    = addr - BASE_ADDR;
    assign in_window = (addr >= BASE_ADDR) && (offset[15:12] == 4'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_clk_q <= 1'b0;
            wr      <= 1'b0;
            wr_word <= '0;
            wr_lane <= '0;
            wr_data <= '0;
        end else begin
            w_clk_q <= w_clk;
            wr      <= w_rise && in_window;
            if (w_rise) begin
                wr_word <= offset[11:4];
                wr_lane <= offset[3:0];
                wr_data <= data;
            end
        end
    end

endmodule

// File: rtl/gty_tx_pattern_seq.sv
// GPIO-programmable TX pattern sequencer replaying a small RAM onto the GTY TX bus.
// Defining GTY_TX_PRBS_MODE_EN adds a PRBS31 generator selected by CTRL.prbs.
module gty_tx_pattern_seq
    import gty_dbg_pkg::*;
#(
    parameter int unsigned DATA_W    = 80,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FLAG_W    = 32,
    parameter logic [15:0] BASE_ADDR = 16'h0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       gpio_in,
    output logic [31:0]       gpio_out,
    input  logic [31:0]       gty_fast_flags_in,
    output logic [FLAG_W-1:0] gty_fast_flags_out,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] gty_tx_data_out,
    output logic              seq_active
);

    localparam int unsigned BYTES  = (DATA_W + 7) / 8;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned FBYTES = FLAG_W / 8;

    logic              wr;
    logic [7:0]        wr_word;
    logic [3:0]        wr_lane;
    logic [7:0]        wr_data;
    logic [7:0]        pat_word;
    logic              wr_ctrl, wr_last, wr_flag, wr_pat;
    logic              start_cmd, stop_cmd, go;
    logic [DATA_W-1:0] lane_mask, lane_val;
    logic [31:0]       status;
    logic              unused_gpio;

    seq_state_e        state_q;
    logic [AW-1:0]     idx_q, last_q;
    logic [15:0]       loop_cnt_q;
    logic              loop_q;
    logic              prbs_mode;
    logic [DATA_W-1:0] prbs_word;
    logic [DATA_W-1:0] mem_q [DEPTH];

    gpio_byte_wr_decoder #(
        .BASE_ADDR(BASE_ADDR)
    ) u_wr_dec (
        .clk    (clk),
        .rst    (rst),
        .addr   (gpio_in[15:0]),
        .data   (gpio_in[23:16]),
        .w_clk  (gpio_in[24]),
        .wr     (wr),
        .wr_word(wr_word),
        .wr_lane(wr_lane),
        .wr_data(wr_data)
    );

    assign unused_gpio = ^gpio_in[31:26];

    assign pat_word  = wr_word - OFF_PAT[11:4];
    assign wr_ctrl   = wr && ({wr_word, wr_lane} == OFF_CTRL);
    assign wr_last   = wr && ({wr_word, wr_lane} == OFF_LAST);
    assign wr_flag   = wr && (wr_word == OFF_FLAG[11:4]) && (32'(wr_lane) < FBYTES);
    assign wr_pat    = wr && (wr_word >= OFF_PAT[11:4]) && (32'(pat_word) < DEPTH)
                       && (32'(wr_lane) < BYTES);
    assign start_cmd = wr_ctrl && wr_data[CTRL_START];
    assign stop_cmd  = wr_ctrl && wr_data[CTRL_STOP];
    assign go        = start_cmd && !stop_cmd && (state_q != StRun);

    // Shifting within DATA_W drops any top-byte bits that fall past the word
    assign lane_mask = DATA_W'(8'hFF) << {wr_lane, 3'b000};
    assign lane_val  = DATA_W'(wr_data) << {wr_lane, 3'b000};

    assign seq_active = (state_q == StRun);
    assign status     = {loop_cnt_q, prbs_mode, 5'b0, state_q, 8'(last_q)};

    always_ff @(posedge clk) begin
        if (wr_pat) begin
            mem_q[pat_word[AW-1:0]] <= (mem_q[pat_word[AW-1:0]] & ~lane_mask) | lane_val;
        end
    end

`ifdef GTY_TX_PRBS_MODE_EN
    logic        prbs_q;
    logic [30:0] lfsr_q, lfsr_nxt;

    always_comb begin
        lfsr_nxt  = lfsr_q;
        prbs_word = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            prbs_word[i] = lfsr_nxt[PRBS_TAP_A] ^ lfsr_nxt[PRBS_TAP_B];
            lfsr_nxt     = {lfsr_nxt[29:0], prbs_word[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prbs_q <= 1'b0;
            lfsr_q <= '1;
        end else begin
            if (wr_ctrl) prbs_q <= wr_data[CTRL_PRBS];
            if (go) begin
                lfsr_q <= '1;
            end else if (state_q == StRun && tx_ready && prbs_q) begin
                lfsr_q <= lfsr_nxt;
            end
        end
    end

    assign prbs_mode = prbs_q;
`else
    assign prbs_mode = 1'b0;
    assign prbs_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            idx_q              <= '0;
            last_q             <= '0;
            loop_q             <= 1'b0;
            loop_cnt_q         <= '0;
            gty_tx_data_out    <= '0;
            gty_fast_flags_out <= '0;
            gpio_out           <= '0;
        end else begin
            gpio_out <= gpio_in[25] ? status : gty_fast_flags_in;
            if (wr_ctrl) loop_q <= wr_data[CTRL_LOOP];
            if (wr_last) last_q <= wr_data[AW-1:0];
            if (wr_flag) gty_fast_flags_out[32'(wr_lane) * 8 +: 8] <= wr_data;

            if (stop_cmd) begin
                state_q         <= StIdle;
                gty_tx_data_out <= '0;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        gty_tx_data_out <= '0;
                        if (go) begin
                            state_q <= StRun;
                            idx_q   <= '0;
                        end
                    end
                    StRun: begin
                        if (tx_ready && prbs_mode) begin
                            gty_tx_data_out <= prbs_word;
                        end else if (tx_ready) begin
                            gty_tx_data_out <= mem_q[idx_q];
                            if (idx_q != last_q) begin
                                idx_q <= idx_q + AW'(1);
                            end else if (loop_q) begin
                                idx_q <= '0;
                                if (loop_cnt_q != 16'hFFFF) loop_cnt_q <= loop_cnt_q + 16'd1;
                            end else begin
                                state_q <= StDone;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gty_tx_pattern_seq.sv
// Directed self-checking bench for gty_tx_pattern_seq; the PRBS scenario is
// compiled in when GTY_TX_PRBS_MODE_EN is defined.
module tb_gty_tx_pattern_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic [31:0] gty_fast_flags_in = '0;
    logic [31:0] gty_fast_flags_out;
    logic        tx_ready = 1'b0;
    logic [79:0] gty_tx_data_out;
    logic        seq_active;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] A_CTRL = 16'h0100;
    localparam logic [15:0] A_LAST = 16'h0101;
    localparam logic [15:0] A_FLAG = 16'h0110;
    localparam logic [15:0] A_PAT  = 16'h0200;

    gty_tx_pattern_seq #(
        .DATA_W   (80),
        .DEPTH    (16),
        .FLAG_W   (32),
        .BASE_ADDR(16'h0100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .gpio_in           (gpio_in),
        .gpio_out          (gpio_out),
        .gty_fast_flags_in (gty_fast_flags_in),
        .gty_fast_flags_out(gty_fast_flags_out),
        .tx_ready          (tx_ready),
        .gty_tx_data_out   (gty_tx_data_out),
        .seq_active        (seq_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise w_clk for one cycle; the write has committed when this returns
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        gpio_in = {6'b0, gpio_in[25], 1'b1, d, a};
        tick();
        gpio_in[24] = 1'b0;
        tick();
    endtask

    task automatic wr_pat_word(input int w, input logic [79:0] v);
        for (int b = 0; b < 10; b++) begin
            wr(A_PAT + 16'(w * 16 + b), v[b*8 +: 8]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gpio_in[25] = 1'b1;
        gty_fast_flags_in = 32'h1234_5678;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gpio_out !== 32'h0) begin
            n_bad++; $display("FAIL rst_status: got %h want %h", gpio_out, 32'h0);
        end
        n_cmp++;
        if (gty_tx_data_out !== 80'h0) begin
            n_bad++; $display("FAIL rst_data: got %h want 0", gty_tx_data_out);
        end
        n_cmp++;
        if (seq_active !== 1'b0) begin
            n_bad++; $display("FAIL rst_active: got %b want 0", seq_active);
        end
        n_cmp++;
        if (gty_fast_flags_out !== 32'h0) begin
            n_bad++; $display("FAIL rst_flags: got %h want 0", gty_fast_flags_out);
        end
        gpio_in[25] = 1'b0;
        tick();
        n_cmp++;
        if (gpio_out !== 32'h1234_5678) begin
            n_bad++; $display("FAIL rd_flags_in: got %h want %h", gpio_out, 32'h1234_5678);
        end
    endtask

    task automatic test_one_shot();
        logic [79:0] exp [3];
        exp = '{80'h1, 80'h2, 80'h0};
        wr_pat_word(0, 80'h1);
        wr_pat_word(1, 80'h2);
        wr(A_LAST, 8'h01);
        tx_ready = 1'b1;
        wr(A_CTRL, 8'h01);
        n_cmp++;
        if (seq_active !== 1'b1 || gty_tx_data_out !== 80'h0) begin
            n_bad++;
            $display("FAIL os_start: got active=%b data=%h want active=1 data=0",
                     seq_active, gty_tx_data_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (gty_tx_data_out !== exp[i]) begin
                n_bad++;
                $display("FAIL os_word%0d: got %h want %h", i, gty_tx_data_out, exp[i]);
            end
        end
        n_cmp++;
        if (seq_active !== 1'b0) begin
            n_bad++; $display("FAIL os_active_done: got %b want 0", seq_active);
        end
        gpio_in[25] = 1'b1;
        tick();
        n_cmp++;
        if (gpio_out !== 32'h0000_0201) begin
            n_bad++; $display("FAIL os_status: got %h want %h", gpio_out, 32'h0000_0201);
        end
    endtask

    task automatic test_loop();
        logic [79:0] exp;
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h05);
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i % 2 == 0) ? 80'h1 : 80'h2;
            n_cmp++;
            if (gty_tx_data_out !== exp) begin
                n_bad++;
                $display("FAIL loop_cyc%0d: got %h want %h", i, gty_tx_data_out, exp);
            end
        end
        tx_ready = 1'b0;
        tick();
        n_cmp++;
        if (gty_tx_data_out !== 80'h2) begin
            n_bad++; $display("FAIL loop_hold: got %h want 2", gty_tx_data_out);
        end
        n_cmp++;
        if (gpio_out !== 32'h0005_0101) begin
            n_bad++; $display("FAIL loop_cnt: got %h want %h", gpio_out, 32'h0005_0101);
        end
    endtask

    task automatic test_ready_gating();
        logic        rdy [4];
        logic [79:0] exp [4];
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp = '{80'h1, 80'h1, 80'h1, 80'h2};
        for (int i = 0; i < 4; i++) begin
            tx_ready = rdy[i];
            tick();
            n_cmp++;
            if (gty_tx_data_out !== exp[i]) begin
                n_bad++;
                $display("FAIL gate_cyc%0d: got %h want %h", i, gty_tx_data_out, exp[i]);
            end
        end
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h02);
        n_cmp++;
        if (seq_active !== 1'b0 || gty_tx_data_out !== 80'h0) begin
            n_bad++;
            $display("FAIL stop: got active=%b data=%h want active=0 data=0",
                     seq_active, gty_tx_data_out);
        end
    endtask

    task automatic test_start_stop();
        tx_ready = 1'b1;
        wr(A_CTRL, 8'h03);
        n_cmp++;
        if (seq_active !== 1'b0) begin
            n_bad++; $display("FAIL ss_active: got %b want 0", seq_active);
        end
        tick();
        n_cmp++;
        if (gpio_out !== 32'h0006_0001 || gty_tx_data_out !== 80'h0) begin
            n_bad++;
            $display("FAIL ss_status: got %h data=%h want %h data=0",
                     gpio_out, gty_tx_data_out, 32'h0006_0001);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_wclk_hold();
        gpio_in = {6'b0, gpio_in[25], 1'b1, 8'hA5, A_FLAG};
        tick();
        gpio_in[23:16] = 8'h3C;
        repeat (4) tick();
        gpio_in[24] = 1'b0;
        tick();
        n_cmp++;
        if (gty_fast_flags_out !== 32'h0000_00A5) begin
            n_bad++;
            $display("FAIL hold_once: got %h want %h", gty_fast_flags_out, 32'h0000_00A5);
        end
        wr(A_FLAG + 16'd3, 8'h5A);
        wr(16'h1110, 8'hFF);
        wr(16'h00FF, 8'hFF);
        wr(A_FLAG + 16'd4, 8'hFF);
        n_cmp++;
        if (gty_fast_flags_out !== 32'h5A00_00A5) begin
            n_bad++;
            $display("FAIL flag_window: got %h want %h", gty_fast_flags_out, 32'h5A00_00A5);
        end
    endtask

    task automatic test_ram_write_in_run();
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h05);
        wr_pat_word(1, 80'h7);
        tx_ready = 1'b1;
        tick();
        n_cmp++;
        if (gty_tx_data_out !== 80'h1) begin
            n_bad++; $display("FAIL rw_word0: got %h want 1", gty_tx_data_out);
        end
        tick();
        n_cmp++;
        if (gty_tx_data_out !== 80'h7) begin
            n_bad++; $display("FAIL rw_word1: got %h want 7", gty_tx_data_out);
        end
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h02);
    endtask

    task automatic test_reset_in_run();
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h05);
        tx_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (gty_tx_data_out !== 80'h0 || seq_active !== 1'b0 || gpio_out !== 32'h0) begin
            n_bad++;
            $display("FAIL rr_reset: got data=%h active=%b rb=%h want 0/0/0",
                     gty_tx_data_out, seq_active, gpio_out);
        end
        wr(A_CTRL, 8'h01);
        tick();
        n_cmp++;
        if (gty_tx_data_out !== 80'h1) begin
            n_bad++; $display("FAIL rr_ram_kept: got %h want 1", gty_tx_data_out);
        end
        tick();
        n_cmp++;
        if (gty_tx_data_out !== 80'h0 || seq_active !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_done: got data=%h active=%b want 0/0",
                     gty_tx_data_out, seq_active);
        end
    endtask

    task automatic test_last_zero();
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h05);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (gty_tx_data_out !== 80'h1) begin
                n_bad++; $display("FAIL l0_cyc%0d: got %h want 1", i, gty_tx_data_out);
            end
        end
        tx_ready = 1'b0;
        tick();
        n_cmp++;
        if (gpio_out !== 32'h0003_0100) begin
            n_bad++; $display("FAIL l0_status: got %h want %h", gpio_out, 32'h0003_0100);
        end
        wr(A_LAST, 8'h11);
        tick();
        n_cmp++;
        if (gpio_out !== 32'h0003_0101) begin
            n_bad++; $display("FAIL last_mod: got %h want %h", gpio_out, 32'h0003_0101);
        end
        wr(A_CTRL, 8'h02);
    endtask

`ifdef GTY_TX_PRBS_MODE_EN
    task automatic test_prbs();
        logic [30:0] s;
        logic [79:0] w0, w1;
        s = '1;
        for (int i = 0; i < 80; i++) begin
            w0[i] = s[30] ^ s[27];
            s = {s[29:0], w0[i]};
        end
        for (int i = 0; i < 80; i++) begin
            w1[i] = s[30] ^ s[27];
            s = {s[29:0], w1[i]};
        end
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h11);
        tx_ready = 1'b1;
        tick();
        n_cmp++;
        if (gty_tx_data_out !== w0) begin
            n_bad++; $display("FAIL prbs_w0: got %h want %h", gty_tx_data_out, w0);
        end
        tick();
        n_cmp++;
        if (gty_tx_data_out !== w1) begin
            n_bad++; $display("FAIL prbs_w1: got %h want %h", gty_tx_data_out, w1);
        end
        tx_ready = 1'b0;
        tick();
        n_cmp++;
        if (gpio_out !== 32'h0003_8101) begin
            n_bad++; $display("FAIL prbs_status: got %h want %h", gpio_out, 32'h0003_8101);
        end
    endtask
`else
    task automatic test_prbs_off();
        tx_ready = 1'b0;
        wr(A_CTRL, 8'h10);
        tick();
        n_cmp++;
        if (gpio_out !== 32'h0003_0001) begin
            n_bad++; $display("FAIL prbs_off: got %h want %h", gpio_out, 32'h0003_0001);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_one_shot();
        test_loop();
        test_ready_gating();
        test_start_stop();
        test_wclk_hold();
        test_ram_write_in_run();
        test_reset_in_run();
        test_last_zero();
`ifdef GTY_TX_PRBS_MODE_EN
        test_prbs();
`else
        test_prbs_off();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
